readout_sequencer: RTL and testbench
====================================

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 Parameter PACKAGE_LENGTH, default 518: words per channel package, 1..MEMORY_DEPTH (elaboration error otherwise).
REQ-002 Parameter MEMORY_DEPTH, default 24576: ring-buffer depth in words.
REQ-003 Parameter N_CHANNELS, default 16: channels per event, 1..64.
REQ-004 Parameter PILEUP_W, default 6: width of the pending-event counter.
REQ-005 Derived: AW=clog2(MEMORY_DEPTH), CW=max(1,clog2(N_CHANNELS)), LW=clog2(PACKAGE_LENGTH+1).
REQ-006 clk  in  1  system clock; single clock domain, all logic on its rising edge.
REQ-007 live_rising  in  1  reset; synchronous, active-high.
REQ-008 read_start  in  1  one-cycle pulse: one complete event is stored in memory.
REQ-009 ch_enable  in  N_CHANNELS  channel mask; bit i set = read channel i.
REQ-010 out_ready  in  1  downstream ready; low stalls reading.
REQ-011 ren  out  1  memory read enable.
REQ-012 raddr  out  AW  memory read address.
REQ-013 input_id  out  CW  channel index of the current package.
REQ-014 sop / eop  out  1 each  first / last word of a package, qualified by ren.
REQ-015 event_done  out  1  one-cycle pulse when an event is retired.
REQ-016 n_pileup  out  PILEUP_W  number of pending events.
REQ-017 overflow  out  1  sticky flag: an event was dropped.

Function
REQ-018 FSM states: IDLE, LOAD, READ, RETIRE.
REQ-019 IDLE->LOAD when n_pileup>0; otherwise stay in IDLE.
REQ-020 LOAD (1 cycle): latch ch_enable into mask_q; set input_id to the lowest enabled channel, raddr=base_addr, cnt=0.
REQ-021 LOAD->READ if mask_q is nonzero; LOAD->RETIRE if mask_q is zero (no reads).
REQ-022 ren = (state==READ) && out_ready, combinational; raddr, cnt and input_id advance only in cycles where ren=1.
REQ-023 sop = ren && cnt==0; eop = ren && cnt==PACKAGE_LENGTH-1.
REQ-024 Non-eop read: raddr <= (raddr==MEMORY_DEPTH-1) ? 0 : raddr+1; cnt <= cnt+1.
REQ-025 Eop with a higher enabled channel in mask_q: input_id <= next enabled channel, raddr <= base_addr, cnt <= 0; stay in READ with no bubble.
REQ-026 Eop on the highest enabled channel: go to RETIRE.
REQ-027 RETIRE (1 cycle): event_done=1; base_addr <= base_addr+PACKAGE_LENGTH, minus MEMORY_DEPTH if the sum is >= MEMORY_DEPTH (no % operator); n_pileup decrements; go to IDLE.
REQ-028 Pending counter: read_start increments n_pileup; read_start in the same cycle as the RETIRE decrement leaves it unchanged.
REQ-029 read_start when n_pileup is at its maximum (2^PILEUP_W-1) and no decrement occurs that cycle: the event is dropped, the count is held, overflow <= 1.
REQ-030 Changes to ch_enable after LOAD have no effect on the event in progress.
REQ-031 out_ready low: outputs hold, ren=0, sop=0, eop=0; an arbitrarily long stall loses no data.

Reset
REQ-032 live_rising=1 at any time, including mid-event: next cycle state=IDLE; ren, sop, eop, event_done=0; raddr, input_id, cnt, base_addr, n_pileup, mask_q=0; overflow=0.
REQ-033 read_start coincident with live_rising is ignored.

Structure
REQ-034 Package readout_pkg holds the state enum, the parameter defaults and the clog2 helper function.
REQ-035 Sub-module next_channel_sel: combinational; given mask_q and the current id, returns the next-higher enabled id and a last flag; reused for first-channel lookup with the current id forced below 0.

Verification
REQ-036 PL=4, DEPTH=16, N_CH=4, mask=0xF, one read_start: 16 ren cycles; raddr 0..3 repeated with input_id 0,1,2,3; sop/eop on every 4th word; event_done once; base_addr=4.
REQ-037 PL=4, DEPTH=10, three events: third event raddr sequence is 8,9,0,1 per channel; base_addr after the third event is 2.
REQ-038 mask=0b1010: only ids 1 and 3 read, 8 ren cycles; mask=0: event_done 2 cycles after LOAD entry with no ren, n_pileup decrements.
REQ-039 PILEUP_W=2, 5 read_start pulses while reading is stalled: n_pileup=3, overflow=1; read_start coincident with RETIRE keeps n_pileup unchanged.
REQ-040 out_ready toggled randomly: the ren/raddr stream equals the unstalled stream; live_rising asserted at word 7: all outputs 0 next cycle, then a fresh read_start reads from address 0.

Source files
------------

// File: rtl/readout_pkg.sv
// Shared types, parameter defaults and elaboration helpers for the readout sequencer.
package readout_pkg;

    localparam int unsigned DEF_PACKAGE_LENGTH = 518;
    localparam int unsigned DEF_MEMORY_DEPTH   = 24576;
    localparam int unsigned DEF_N_CHANNELS     = 16;
    localparam int unsigned DEF_PILEUP_W       = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        READ   = 2'd2,
        RETIRE = 2'd3
    } state_t;

    // Ceiling log2 for elaboration-time width derivation.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/next_channel_sel.sv
// Finds the lowest enabled channel above cur_id (or from channel 0 when from_start is set).
module next_channel_sel #(
    parameter int unsigned N_CHANNELS = 16,
    parameter int unsigned CW         = 4
) (
    input  logic [N_CHANNELS-1:0] mask,
    input  logic [CW-1:0]         cur_id,
    input  logic                  from_start,
    output logic [CW-1:0]         next_id,
    output logic                  last
);

    // Descending scan so the lowest qualifying channel wins; last means none qualified.
    always_comb begin
        next_id = '0;
        last    = 1'b1;
        for (int i = int'(N_CHANNELS) - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(cur_id)))) begin
                next_id = CW'(i);
                last    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/readout_sequencer.sv
// Walks a ring buffer one event at a time, emitting one fixed-length package per enabled channel.
module readout_sequencer
    import readout_pkg::*;
#(
    parameter  int unsigned PACKAGE_LENGTH = DEF_PACKAGE_LENGTH,
    parameter  int unsigned MEMORY_DEPTH   = DEF_MEMORY_DEPTH,
    parameter  int unsigned N_CHANNELS     = DEF_N_CHANNELS,
    parameter  int unsigned PILEUP_W       = DEF_PILEUP_W,
    localparam int unsigned AW             = clog2(MEMORY_DEPTH),
    localparam int unsigned CW             = (clog2(N_CHANNELS) > 1) ? clog2(N_CHANNELS) : 1,
    localparam int unsigned LW             = clog2(PACKAGE_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  live_rising,
    input  logic                  read_start,
    input  logic [N_CHANNELS-1:0] ch_enable,
    input  logic                  out_ready,
    output logic                  ren,
    output logic [AW-1:0]         raddr,
    output logic [CW-1:0]         input_id,
    output logic                  sop,
    output logic                  eop,
    output logic                  event_done,
    output logic [PILEUP_W-1:0]   n_pileup,
    output logic                  overflow
);

    if (PACKAGE_LENGTH < 1 || PACKAGE_LENGTH > MEMORY_DEPTH) begin : g_bad_length
        $error("PACKAGE_LENGTH must be within 1..MEMORY_DEPTH");
    end
    if (N_CHANNELS < 1 || N_CHANNELS > 64) begin : g_bad_channels
        $error("N_CHANNELS must be within 1..64");
    end

    localparam logic [PILEUP_W-1:0] PILE_MAX = '1;

    state_t                  state, state_nx;
    logic [N_CHANNELS-1:0]   mask_q;
    logic [LW-1:0]           cnt;
    logic [AW-1:0]           base_addr;
    logic [AW-1:0]           raddr_inc;
    logic [AW:0]             base_sum;
    logic [AW-1:0]           base_nx;
    logic [CW-1:0]           nxt_id, first_id;
    logic                    nxt_last, first_none;
    logic                    pile_inc, pile_dec;

    next_channel_sel #(.N_CHANNELS(N_CHANNELS), .CW(CW)) u_next (
        .mask       (mask_q),
        .cur_id     (input_id),
        .from_start (1'b0),
        .next_id    (nxt_id),
        .last       (nxt_last)
    );

    // First-channel lookup works on the live mask because it is latched in the same cycle.
    next_channel_sel #(.N_CHANNELS(N_CHANNELS), .CW(CW)) u_first (
        .mask       (ch_enable),
        .cur_id     (CW'(0)),
        .from_start (1'b1),
        .next_id    (first_id),
        .last       (first_none)
    );

    assign ren = (state == READ) && out_ready;
    assign sop = ren && (cnt == '0);
    assign eop = ren && (cnt == LW'(PACKAGE_LENGTH - 1));

    assign raddr_inc = (raddr == AW'(MEMORY_DEPTH - 1)) ? '0 : raddr + AW'(1);
    assign base_sum  = {1'b0, base_addr} + (AW+1)'(PACKAGE_LENGTH);
    assign base_nx   = (base_sum >= (AW+1)'(MEMORY_DEPTH)) ?
                       AW'(base_sum - (AW+1)'(MEMORY_DEPTH)) : AW'(base_sum);

    assign pile_inc = read_start;
    assign pile_dec = (state == RETIRE);

    always_ff @(posedge clk) begin
        if (live_rising) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (n_pileup != '0) state_nx = LOAD;
            LOAD:    state_nx = first_none ? RETIRE : READ;
            READ:    if (eop && nxt_last) state_nx = RETIRE;
            RETIRE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read pointer, package word counter, channel cursor and event base address.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            mask_q    <= '0;
            input_id  <= '0;
            raddr     <= '0;
            cnt       <= '0;
            base_addr <= '0;
        end else begin
            case (state)
                LOAD: begin
                    mask_q   <= ch_enable;
                    input_id <= first_id;
                    raddr    <= base_addr;
                    cnt      <= '0;
                end
                READ: begin
                    if (ren) begin
                        if (!eop) begin
                            raddr <= raddr_inc;
                            cnt   <= cnt + LW'(1);
                        end else if (!nxt_last) begin
                            input_id <= nxt_id;
                            raddr    <= base_addr;
                            cnt      <= '0;
                        end
                    end
                end
                RETIRE:  base_addr <= base_nx;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (live_rising) begin
            event_done <= 1'b0;
        end else begin
            event_done <= (state == RETIRE);
        end
    end

    // Pending-event counter; a start arriving with the counter full and no retire is dropped.
    always_ff @(posedge clk) begin
        if (live_rising) begin
            n_pileup <= '0;
            overflow <= 1'b0;
        end else if (pile_inc && !pile_dec) begin
            if (n_pileup == PILE_MAX) begin
                overflow <= 1'b1;
            end else begin
                n_pileup <= n_pileup + PILEUP_W'(1);
            end
        end else if (pile_dec && !pile_inc) begin
            n_pileup <= n_pileup - PILEUP_W'(1);
        end
    end

endmodule

// File: tb/tb_readout_sequencer.sv
// Scoreboard bench for readout_sequencer: expected read words are queued at each read_start.
module tb_readout_sequencer;

    localparam int unsigned PL    = 4;
    localparam int unsigned DEPTH = 10;
    localparam int unsigned NCH   = 4;
    localparam int unsigned PW    = 2;

    logic           clk         = 1'b0;
    logic           live_rising = 1'b1;
    logic           read_start  = 1'b0;
    logic           out_ready   = 1'b0;
    logic [NCH-1:0] ch_enable   = '0;
    logic           ren, sop, eop, event_done, overflow;
    logic [3:0]     raddr;
    logic [1:0]     input_id;
    logic [PW-1:0]  n_pileup;

    int vectors     = 0;
    int miscompares = 0;
    int exp_q[$];
    int done_q[$];
    int mon_words   = 0;
    int m_base      = 0;
    int ready_mode  = 0;

    always #5 clk = ~clk;

    readout_sequencer #(
        .PACKAGE_LENGTH (PL),
        .MEMORY_DEPTH   (DEPTH),
        .N_CHANNELS     (NCH),
        .PILEUP_W       (PW)
    ) dut (
        .clk         (clk),
        .live_rising (live_rising),
        .read_start  (read_start),
        .ch_enable   (ch_enable),
        .out_ready   (out_ready),
        .ren         (ren),
        .raddr       (raddr),
        .input_id    (input_id),
        .sop         (sop),
        .eop         (eop),
        .event_done  (event_done),
        .n_pileup    (n_pileup),
        .overflow    (overflow)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int enc(input int a, input int id, input int s, input int e);
        return a * 256 + id * 4 + s * 2 + e;
    endfunction

    // Downstream ready: 0 = stalled, 1 = always ready, otherwise random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (ren) begin
            if (exp_q.size() == 0) check_val("unexpected_ren", 32'(ren), 32'd0);
            else check_val("word", enc(int'(raddr), int'(input_id), int'(sop), int'(eop)),
                           exp_q.pop_front());
            mon_words++;
        end
        if (event_done) begin
            if (done_q.size() == 0) check_val("unexpected_done", 32'(event_done), 32'd0);
            else check_val("event_words", mon_words, done_q.pop_front());
            mon_words = 0;
        end
        if (live_rising) begin
            exp_q.delete();
            done_q.delete();
            mon_words = 0;
        end
    end

    task automatic push_event(input logic [NCH-1:0] mask);
        int n;
        n = 0;
        for (int ch = 0; ch < int'(NCH); ch++) begin
            if (mask[ch]) begin
                for (int w = 0; w < int'(PL); w++) begin
                    exp_q.push_back(enc((m_base + w) % int'(DEPTH), ch,
                                        (w == 0) ? 1 : 0, (w == int'(PL) - 1) ? 1 : 0));
                    n++;
                end
            end
        end
        done_q.push_back(n);
        m_base = (m_base + int'(PL)) % int'(DEPTH);
    endtask

    task automatic start_event(input logic [NCH-1:0] mask, input bit accept);
        @(posedge clk); #1;
        ch_enable  = mask;
        read_start = 1'b1;
        if (accept) push_event(mask);
        @(posedge clk); #1;
        read_start = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        live_rising = 1'b1;
        read_start  = 1'b0;
        @(posedge clk); #1;
        live_rising = 1'b0;
        m_base      = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && done_q.size() == 0 && n_pileup == '0) break;
        end
        check_val("drain", exp_q.size() + done_q.size(), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int i;
        repeat (3) @(posedge clk);
        #1 live_rising = 1'b0;
        @(negedge clk);
        check_val("rst_ren", 32'(ren), 32'd0);
        check_val("rst_raddr", 32'(raddr), 32'd0);
        check_val("rst_id", 32'(input_id), 32'd0);
        check_val("rst_pileup", 32'(n_pileup), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        check_val("rst_done", 32'(event_done), 32'd0);

        // Single full event, then three events wrapping the ring.
        ready_mode = 1;
        start_event(4'hF, 1'b1);
        wait_idle();
        reset_dut();
        repeat (3) start_event(4'hF, 1'b1);
        wait_idle();

        // Sparse mask from base 2; the mask change mid-event must not matter.
        start_event(4'hA, 1'b1);
        repeat (3) @(posedge clk);
        #1 ch_enable = 4'hF;
        wait_idle();

        // Empty mask: no reads, retire only.
        @(posedge clk); #1;
        ch_enable  = 4'h0;
        read_start = 1'b1;
        push_event(4'h0);
        @(posedge clk); #1;
        read_start = 1'b0;
        for (i = 1; i < 20; i++) begin
            @(negedge clk);
            if (event_done) break;
        end
        check_val("empty_done_latency", i, 32'd4);
        check_val("empty_pileup", 32'(n_pileup), 32'd0);
        start_event(4'hF, 1'b1);
        wait_idle();

        // Pile-up saturation while stalled, then a start coincident with retire.
        reset_dut();
        ready_mode = 0;
        repeat (3) start_event(4'hF, 1'b1);
        repeat (2) start_event(4'hF, 1'b0);
        @(negedge clk);
        check_val("sat_pileup", 32'(n_pileup), 32'd3);
        check_val("sat_overflow", 32'(overflow), 32'd1);
        ready_mode = 1;
        for (i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ren && eop && input_id == 2'd3) break;
        end
        check_val("last_eop_seen", (i < 200) ? 32'd1 : 32'd0, 32'd1);
        start_event(4'hF, 1'b1);
        @(negedge clk);
        check_val("retire_coincident_pileup", 32'(n_pileup), 32'd3);
        wait_idle();
        check_val("overflow_sticky", 32'(overflow), 32'd1);

        // Random back-pressure.
        reset_dut();
        @(negedge clk);
        check_val("overflow_cleared", 32'(overflow), 32'd0);
        ready_mode = 2;
        repeat (3) start_event(4'hF, 1'b1);
        wait_idle();
        repeat (2) start_event(4'h5, 1'b1);
        wait_idle();

        // Reset in the middle of an event; coincident start is ignored.
        ready_mode = 1;
        start_event(4'hF, 1'b1);
        for (i = 0; i < 100; i++) begin
            @(negedge clk);
            if (mon_words >= 7) break;
        end
        @(posedge clk); #1;
        live_rising = 1'b1;
        read_start  = 1'b1;
        @(posedge clk); #1;
        live_rising = 1'b0;
        read_start  = 1'b0;
        m_base      = 0;
        @(negedge clk);
        check_val("mid_rst_ren", 32'(ren), 32'd0);
        check_val("mid_rst_raddr", 32'(raddr), 32'd0);
        check_val("mid_rst_id", 32'(input_id), 32'd0);
        check_val("mid_rst_sop_eop", 32'({sop, eop}), 32'd0);
        check_val("mid_rst_done", 32'(event_done), 32'd0);
        check_val("mid_rst_pileup", 32'(n_pileup), 32'd0);
        start_event(4'hF, 1'b1);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
